// File: rtl/rv32i_idtop.sv
// RV32I instruction-decode stage.
// Holds the 32x32 integer register file, reads rs1/rs2 for the incoming (or held)
// instruction word, and registers pc/iw/operands into the ID/EX pipeline register.
//
// Ports:
//   clk_i        stage clock, rising edge
//   rst_ni       asynchronous active-low reset
//   pc_i, iw_i   pc and instruction word from IF; valid_i marks a real instruction
//   stall_i      hold ID/EX contents (operands still refresh from the register file)
//   flush_i      load a bubble into ID/EX; wins over stall_i
//   wb_en_i, wb_rd_i, wb_data_i   writeback port into the register file
//   pc_o, iw_o, rs1_data_o, rs2_data_o, valid_o   ID/EX register outputs to EX
module rv32i_idtop #(
  parameter int unsigned Xlen  = 32,
  parameter logic [31:0] NopIw = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [Xlen-1:0] pc_i,
  input  logic [31:0]     iw_i,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [Xlen-1:0] wb_data_i,
  output logic [Xlen-1:0] pc_o,
  output logic [31:0]     iw_o,
  output logic [Xlen-1:0] rs1_data_o,
  output logic [Xlen-1:0] rs2_data_o,
  output logic            valid_o
);

  logic [Xlen-1:0] rf_q [32];

  logic [Xlen-1:0] pc_q, pc_d;
  logic [31:0]     iw_q, iw_d;
  logic [Xlen-1:0] rs1_q, rs1_d;
  logic [Xlen-1:0] rs2_q, rs2_d;
  logic            valid_q, valid_d;

  logic [4:0]      rs1_addr, rs2_addr;
  logic [Xlen-1:0] rs1_rd, rs2_rd;

  // Register file; x0 is never written so it stays zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en_i && (wb_rd_i != 5'd0)) begin
      rf_q[wb_rd_i] <= wb_data_i;
    end
  end

  // While stalled, operands are re-read for the held instruction so a writeback
  // landing during the stall refreshes them.
  always_comb begin
    rs1_addr = stall_i ? iw_q[19:15] : iw_i[19:15];
    rs2_addr = stall_i ? iw_q[24:20] : iw_i[24:20];
  end

  // Read with same-cycle writeback bypass; x0 always reads zero.
  always_comb begin
    rs1_rd = '0;
    rs2_rd = '0;
    if (rs1_addr != 5'd0) begin
      rs1_rd = (wb_en_i && (wb_rd_i == rs1_addr)) ? wb_data_i : rf_q[rs1_addr];
    end
    if (rs2_addr != 5'd0) begin
      rs2_rd = (wb_en_i && (wb_rd_i == rs2_addr)) ? wb_data_i : rf_q[rs2_addr];
    end
  end

  // ID/EX next state: flush > stall > normal.
  always_comb begin
    pc_d    = pc_q;
    iw_d    = iw_q;
    valid_d = valid_q;
    rs1_d   = rs1_rd;
    rs2_d   = rs2_rd;
    if (flush_i) begin
      pc_d    = pc_i;
      iw_d    = NopIw;
      valid_d = 1'b0;
      rs1_d   = '0;
      rs2_d   = '0;
    end else if (!stall_i) begin
      pc_d    = pc_i;
      iw_d    = valid_i ? iw_i : NopIw;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= '0;
      iw_q    <= NopIw;
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      iw_q    <= iw_d;
      valid_q <= valid_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign pc_o       = pc_q;
  assign iw_o       = iw_q;
  assign valid_o    = valid_q;
  assign rs1_data_o = rs1_q;
  assign rs2_data_o = rs2_q;

endmodule
